// File: rtl/sram_tcm_arbiter.sv
// Round-robin arbiter sharing one asynchronous 16-bit SRAM bus between two Avalon-MM requesters.
// Each access runs through registered SETUP / ACCESS / HOLD phases with an IDLE gap between.
module sram_tcm_arbiter #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clk50_clk,
  input  logic        reset_reset_n,
  input  logic [20:0] p0_address,
  input  logic [1:0]  p0_byteenable,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [15:0] p0_writedata,
  output logic [15:0] p0_readdata,
  output logic        p0_waitrequest,
  input  logic [20:0] p1_address,
  input  logic [1:0]  p1_byteenable,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [15:0] p1_writedata,
  output logic [15:0] p1_readdata,
  output logic        p1_waitrequest,
  output logic [20:0] tcm_address_out,
  output logic [1:0]  tcm_byteenable_n_out,
  output logic        tcm_read_n_out,
  output logic        tcm_write_n_out,
  output logic        tcm_chipselect_n_out,
  inout  wire  [15:0] tcm_data
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("SETUP_CYCLES must be in 1..15");
  end
  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access
    $error("ACCESS_CYCLES must be in 1..15");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..15");
  end

  localparam logic [3:0] SetupLoad  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] AccessLoad = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] HoldLoad   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

  state_e      r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;

  logic        w_req0, w_req1, w_grant, w_start, w_cmpl;
  logic        r_last_grant;

  // Latched transaction: the requesters are not looked at again until IDLE.
  logic        r_grant, w_grant_d;
  logic [20:0] r_addr, w_addr_d;
  logic [1:0]  r_be, w_be_d;
  logic        r_wr, w_wr_d;
  logic [15:0] r_wdata, w_wdata_d;

  logic        r_cs_n, w_cs_n_d;
  logic        r_rd_n, w_rd_n_d;
  logic        r_wr_n, w_wr_n_d;
  logic [1:0]  r_be_n, w_be_n_d;
  logic        r_oe, w_oe_d;
  logic        r_wait0, w_wait0_d;
  logic        r_wait1, w_wait1_d;
  logic [15:0] r_rdata0, r_rdata1;

  assign w_req0  = p0_read | p0_write;
  assign w_req1  = p1_read | p1_write;
  // On a tie the port that was not served last goes next.
  assign w_grant = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
  assign w_start = (r_state == StIdle) & (w_req0 | w_req1);

  always_ff @(posedge clk50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d = StSetup;
          w_cnt_d   = SetupLoad;
        end
      end
      StSetup: begin
        if (r_cnt == 4'd0) begin
          w_state_d = StAccess;
          w_cnt_d   = AccessLoad;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StAccess: begin
        if (r_cnt == 4'd0) begin
          w_state_d = StHold;
          w_cnt_d   = HoldLoad;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StHold: begin
        if (r_cnt == 4'd0) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_grant_d = r_grant;
    w_addr_d  = r_addr;
    w_be_d    = r_be;
    w_wr_d    = r_wr;
    w_wdata_d = r_wdata;
    if (w_start) begin
      w_grant_d = w_grant;
      if (w_grant) begin
        w_addr_d  = p1_address;
        w_be_d    = p1_byteenable;
        w_wr_d    = p1_write;
        w_wdata_d = p1_writedata;
      end else begin
        w_addr_d  = p0_address;
        w_be_d    = p0_byteenable;
        w_wr_d    = p0_write;
        w_wdata_d = p0_writedata;
      end
    end
  end

  // Pin values are decoded from the next state so every pin leaves a flop.
  always_comb begin
    w_cs_n_d  = (w_state_d == StIdle);
    w_rd_n_d  = !((w_state_d == StAccess) && !w_wr_d);
    w_wr_n_d  = !((w_state_d == StAccess) && w_wr_d);
    w_oe_d    = (w_state_d != StIdle) && w_wr_d;
    w_be_n_d  = (w_state_d == StIdle) ? 2'b11 : ~w_be_d;
    w_cmpl    = (r_state == StAccess) && (w_state_d == StHold);
    w_wait0_d = !(w_cmpl && !r_grant);
    w_wait1_d = !(w_cmpl && r_grant);
  end

  always_ff @(posedge clk50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_grant      <= 1'b0;
      r_addr       <= 21'd0;
      r_be         <= 2'b00;
      r_wr         <= 1'b0;
      r_wdata      <= 16'd0;
      r_last_grant <= 1'b1;
      r_cs_n       <= 1'b1;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_be_n       <= 2'b11;
      r_oe         <= 1'b0;
      r_wait0      <= 1'b1;
      r_wait1      <= 1'b1;
      r_rdata0     <= 16'd0;
      r_rdata1     <= 16'd0;
    end else begin
      r_grant <= w_grant_d;
      r_addr  <= w_addr_d;
      r_be    <= w_be_d;
      r_wr    <= w_wr_d;
      r_wdata <= w_wdata_d;
      r_cs_n  <= w_cs_n_d;
      r_rd_n  <= w_rd_n_d;
      r_wr_n  <= w_wr_n_d;
      r_be_n  <= w_be_n_d;
      r_oe    <= w_oe_d;
      r_wait0 <= w_wait0_d;
      r_wait1 <= w_wait1_d;
      if ((r_state == StHold) && (r_cnt == 4'd0)) begin
        r_last_grant <= r_grant;
      end
      if (w_cmpl && !r_wr) begin
        if (r_grant) r_rdata1 <= tcm_data;
        else         r_rdata0 <= tcm_data;
      end
    end
  end

  assign tcm_address_out      = r_addr;
  assign tcm_byteenable_n_out = r_be_n;
  assign tcm_read_n_out       = r_rd_n;
  assign tcm_write_n_out      = r_wr_n;
  assign tcm_chipselect_n_out = r_cs_n;
  assign tcm_data             = r_oe ? r_wdata : 16'hzzzz;
  assign p0_waitrequest       = r_wait0;
  assign p1_waitrequest       = r_wait1;
  assign p0_readdata          = r_rdata0;
  assign p1_readdata          = r_rdata1;

endmodule

// File: tb/tb_sram_tcm_arbiter.sv
// Directed bench for sram_tcm_arbiter: default-timing instance plus a 3/4/2 timing instance,
// each with a tiny SRAM model that drives the bus while chip-select and read strobe are low.
module tb_sram_tcm_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  // Default-parameter DUT.
  logic [20:0] p0_address, p1_address;
  logic [1:0]  p0_byteenable, p1_byteenable;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [15:0] p0_writedata, p1_writedata;
  logic [15:0] p0_readdata, p1_readdata;
  logic        p0_waitrequest, p1_waitrequest;
  logic [20:0] m_addr;
  logic [1:0]  m_be_n;
  logic        m_rd_n, m_wr_n, m_cs_n;
  wire  [15:0] m_data;
  logic [15:0] sram_q;

  // Sweep DUT (SETUP=3, ACCESS=4, HOLD=2).
  logic [20:0] s0_address;
  logic        s0_read;
  logic [15:0] s0_readdata, s1_readdata;
  logic        s0_waitrequest, s1_waitrequest;
  logic [20:0] s_addr;
  logic [1:0]  s_be_n;
  logic        s_rd_n, s_wr_n, s_cs_n;
  wire  [15:0] s_data;

  assign m_data = (!m_cs_n && !m_rd_n) ? sram_q : 16'hzzzz;
  assign s_data = (!s_cs_n && !s_rd_n) ? 16'h5A5A : 16'hzzzz;

  sram_tcm_arbiter u_dut (
    .clk50_clk           (clk),
    .reset_reset_n       (rst_n),
    .p0_address          (p0_address),
    .p0_byteenable       (p0_byteenable),
    .p0_read             (p0_read),
    .p0_write            (p0_write),
    .p0_writedata        (p0_writedata),
    .p0_readdata         (p0_readdata),
    .p0_waitrequest      (p0_waitrequest),
    .p1_address          (p1_address),
    .p1_byteenable       (p1_byteenable),
    .p1_read             (p1_read),
    .p1_write            (p1_write),
    .p1_writedata        (p1_writedata),
    .p1_readdata         (p1_readdata),
    .p1_waitrequest      (p1_waitrequest),
    .tcm_address_out     (m_addr),
    .tcm_byteenable_n_out(m_be_n),
    .tcm_read_n_out      (m_rd_n),
    .tcm_write_n_out     (m_wr_n),
    .tcm_chipselect_n_out(m_cs_n),
    .tcm_data            (m_data)
  );

  sram_tcm_arbiter #(
    .SETUP_CYCLES (3),
    .ACCESS_CYCLES(4),
    .HOLD_CYCLES  (2)
  ) u_dut_sweep (
    .clk50_clk           (clk),
    .reset_reset_n       (rst_n),
    .p0_address          (s0_address),
    .p0_byteenable       (2'b11),
    .p0_read             (s0_read),
    .p0_write            (1'b0),
    .p0_writedata        (16'h0000),
    .p0_readdata         (s0_readdata),
    .p0_waitrequest      (s0_waitrequest),
    .p1_address          (21'd0),
    .p1_byteenable       (2'b00),
    .p1_read             (1'b0),
    .p1_write            (1'b0),
    .p1_writedata        (16'h0000),
    .p1_readdata         (s1_readdata),
    .p1_waitrequest      (s1_waitrequest),
    .tcm_address_out     (s_addr),
    .tcm_byteenable_n_out(s_be_n),
    .tcm_read_n_out      (s_rd_n),
    .tcm_write_n_out     (s_wr_n),
    .tcm_chipselect_n_out(s_cs_n),
    .tcm_data            (s_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Undriven reads as z (4-state) or 0 (2-state); a strong 1 means someone drives.
  function automatic logic bus_has_ones(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i] === 1'b1) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rd_low, cmp_c, idle_c, w_low, w_c;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    p0_address = '0; p0_byteenable = 2'b11; p0_read = 1'b0; p0_write = 1'b0; p0_writedata = '0;
    p1_address = '0; p1_byteenable = 2'b11; p1_read = 1'b0; p1_write = 1'b0; p1_writedata = '0;
    s0_address = '0; s0_read = 1'b0;
    sram_q = 16'hBEEF;

    // Reset values appear without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst cs_n", 32'(m_cs_n), 32'd1);
    check("rst rd_n", 32'(m_rd_n), 32'd1);
    check("rst wr_n", 32'(m_wr_n), 32'd1);
    check("rst be_n", 32'(m_be_n), 32'd3);
    check("rst addr", 32'(m_addr), 32'd0);
    check("rst wait0", 32'(p0_waitrequest), 32'd1);
    check("rst wait1", 32'(p1_waitrequest), 32'd1);
    check("rst rdata0", 32'(p0_readdata), 32'd0);
    check("rst rdata1", 32'(p1_readdata), 32'd0);
    check("rst bus", 32'(bus_has_ones(m_data)), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Parameter sweep read.
    s0_read = 1'b1;
    s0_address = 21'h00042;
    rd_low = 0; cmp_c = 0; idle_c = 0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) check("sw cs_n c1", 32'(s_cs_n), 32'd0);
      if (!s_rd_n) rd_low++;
      if (s_cs_n && idle_c == 0) idle_c = c;
      check($sformatf("sw wait1 c%0d", c), 32'(s1_waitrequest), 32'd1);
      if (!s0_waitrequest) begin
        if (cmp_c == 0) cmp_c = c;
        check("sw rdata", 32'(s0_readdata), 32'h5A5A);
        s0_read = 1'b0;
      end
    end
    check("sw cmpl cycle", 32'(cmp_c), 32'd8);
    check("sw rd_n low", 32'(rd_low), 32'd4);
    check("sw idle cycle", 32'(idle_c), 32'd10);

    // Single read on p0.
    p0_read = 1'b1;
    p0_address = 21'h1ABCD;
    p0_byteenable = 2'b11;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("rd cs_n c%0d", c), 32'(m_cs_n), (c <= 4) ? 32'd0 : 32'd1);
      check($sformatf("rd rd_n c%0d", c), 32'(m_rd_n), (c == 2 || c == 3) ? 32'd0 : 32'd1);
      check($sformatf("rd wr_n c%0d", c), 32'(m_wr_n), 32'd1);
      check($sformatf("rd wait0 c%0d", c), 32'(p0_waitrequest), (c == 4) ? 32'd0 : 32'd1);
      if (c == 1) begin
        check("rd addr", 32'(m_addr), 32'h1ABCD);
        check("rd be_n", 32'(m_be_n), 32'd0);
      end
      if (c == 4) begin
        check("rd rdata0", 32'(p0_readdata), 32'hBEEF);
        p0_read = 1'b0;
      end
    end

    // Single write on p1 with one lane enabled.
    p1_write = 1'b1;
    p1_address = 21'h00010;
    p1_byteenable = 2'b01;
    p1_writedata = 16'h1234;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("wr cs_n c%0d", c), 32'(m_cs_n), (c <= 4) ? 32'd0 : 32'd1);
      check($sformatf("wr wr_n c%0d", c), 32'(m_wr_n), (c == 2 || c == 3) ? 32'd0 : 32'd1);
      check($sformatf("wr rd_n c%0d", c), 32'(m_rd_n), 32'd1);
      check($sformatf("wr wait1 c%0d", c), 32'(p1_waitrequest), (c == 4) ? 32'd0 : 32'd1);
      check($sformatf("wr wait0 c%0d", c), 32'(p0_waitrequest), 32'd1);
      if (c <= 4) check($sformatf("wr data c%0d", c), 32'(m_data), 32'h1234);
      else        check("wr bus released", 32'(bus_has_ones(m_data)), 32'd0);
      if (c == 1) begin
        check("wr be_n", 32'(m_be_n), 32'd2);
        check("wr addr", 32'(m_addr), 32'h00010);
      end
      if (c == 4) p1_write = 1'b0;
    end

    // Contention from reset: p0, p1, p0 (then p0 switches to a write).
    p0_read = 1'b1; p0_address = 21'h00AAA; p0_byteenable = 2'b11;
    p1_read = 1'b1; p1_address = 21'h00555; p1_byteenable = 2'b11;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      check($sformatf("ct wait0 c%0d", c), 32'(p0_waitrequest),
            (c == 4 || c == 14) ? 32'd0 : 32'd1);
      check($sformatf("ct wait1 c%0d", c), 32'(p1_waitrequest), (c == 9) ? 32'd0 : 32'd1);
      if (c == 1 || c == 11) check($sformatf("ct addr c%0d", c), 32'(m_addr), 32'h00AAA);
      if (c == 6) check("ct addr c6", 32'(m_addr), 32'h00555);
      if (c == 5 || c == 10 || c == 15) check($sformatf("ct gap c%0d", c), 32'(m_cs_n), 32'd1);
    end

    // Reset in the middle of a p0 write; last completed grant was p0.
    p1_read = 1'b0;
    p0_read = 1'b0; p0_write = 1'b1; p0_address = 21'h00333; p0_writedata = 16'hC3C3;
    tick();
    tick();
    check("mr wr_n access", 32'(m_wr_n), 32'd0);
    check("mr data access", 32'(m_data), 32'hC3C3);
    #2 rst_n = 1'b0;
    #1;
    check("mr wr_n async", 32'(m_wr_n), 32'd1);
    check("mr cs_n async", 32'(m_cs_n), 32'd1);
    check("mr bus async", 32'(bus_has_ones(m_data)), 32'd0);
    p0_write = 1'b0; p0_read = 1'b1; p0_address = 21'h00777;
    p1_read = 1'b1; p1_address = 21'h00999;
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("mr wait0 rst%0d", c), 32'(p0_waitrequest), 32'd1);
      check($sformatf("mr wait1 rst%0d", c), 32'(p1_waitrequest), 32'd1);
      check($sformatf("mr cs_n rst%0d", c), 32'(m_cs_n), 32'd1);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) check("mr tie addr", 32'(m_addr), 32'h00777);
      if (c == 6) check("mr second addr", 32'(m_addr), 32'h00999);
      check($sformatf("mr wait0 c%0d", c), 32'(p0_waitrequest), (c == 4) ? 32'd0 : 32'd1);
      check($sformatf("mr wait1 c%0d", c), 32'(p1_waitrequest), (c == 9) ? 32'd0 : 32'd1);
      if (c == 4) p0_read = 1'b0;
      if (c == 9) p1_read = 1'b0;
    end

    // Request dropped during SETUP still completes once.
    sram_q = 16'h0F0F;
    p0_read = 1'b1;
    p0_address = 21'h00123;
    w_low = 0; w_c = 0; rd_low = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        check("dr cs_n setup", 32'(m_cs_n), 32'd0);
        p0_read = 1'b0;
      end
      if (!m_rd_n) rd_low++;
      if (!p0_waitrequest) begin
        w_low++;
        w_c = c;
      end
    end
    check("dr wait0 pulses", 32'(w_low), 32'd1);
    check("dr wait0 cycle", 32'(w_c), 32'd4);
    check("dr rd_n low", 32'(rd_low), 32'd2);
    check("dr rdata0", 32'(p0_readdata), 32'h0F0F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_tcm_arbiter.md
# sram_tcm_arbiter

Shares the single external 16-bit asynchronous SRAM tri-state bus between two Avalon-MM-style requesters: port 0 is the PCP, port 1 is the application/host bridge. It arbitrates round-robin, sequences each access through fixed setup, strobe and hold phases, and drives the `tcm_*` pins that leave the FPGA. It sits between the interconnect masters and the board SRAM.

## Interface
Parameters:
- `SETUP_CYCLES`, default 1: cycles with address and chip-select valid before the strobe asserts. Legal range 1..15.
- `ACCESS_CYCLES`, default 2: cycles the `read_n` or `write_n` strobe stays low. Legal range 1..15.
- `HOLD_CYCLES`, default 1: cycles after the strobe with address, chip-select and write data still held. Legal range 1..15.
- A value outside 1..15 is an elaboration error.

Ports:
- `clk50_clk`, in, 1: the only clock.
- `reset_reset_n`, in, 1: asynchronous, active-low reset.
- `pN_address`, in, 21 (N=0,1): word address.
- `pN_byteenable`, in, 2: active-high byte lanes.
- `pN_read`, in, 1; `pN_write`, in, 1: command.
- `pN_writedata`, in, 16.
- `pN_readdata`, out, 16.
- `pN_waitrequest`, out, 1: high except in that port's completion cycle.
- `tcm_address_out`, out, 21.
- `tcm_byteenable_n_out`, out, 2.
- `tcm_read_n_out`, out, 1; `tcm_write_n_out`, out, 1; `tcm_chipselect_n_out`, out, 1.
- `tcm_data`, inout, 16: driven only while a write is in progress, otherwise high-Z.

## Operation
- State machine states: IDLE, SETUP, ACCESS, HOLD. Phase counter is 4 bits wide.
- **IDLE**
  - `cs_n`, `read_n` and `write_n` are high. Data is high-Z.
  - If any port has `read` or `write` asserted, the arbiter grants one port and latches that port's address, byteenable, command and writedata.
  - It then loads the counter with `SETUP_CYCLES-1` and moves to SETUP.
- **Arbitration**
  - If only one port requests, that port is granted.
  - If both request, the port not granted last time wins. `last_grant` resets to 1, so port 0 wins the first tie.
  - A port asserting both `read` and `write` is treated as a write.
- **SETUP**
  - `cs_n` goes low; address and `byteenable_n = ~be` are driven.
  - For a write, data is driven.
  - When the counter reaches 0, go to ACCESS.
- **ACCESS**
  - `read_n` or `write_n` is low.
  - For a read, `tcm_data` is sampled into the readdata register on the last ACCESS cycle edge.
  - Then go to HOLD.
- **HOLD**
  - Strobes are high; `cs_n`, address and write data are unchanged.
  - In the first HOLD cycle the granted port sees `waitrequest=0`, with `readdata` valid for reads.
  - After `HOLD_CYCLES`, go to IDLE and update `last_grant`.
- **Transaction properties**
  - The transaction uses latched values, so requester changes mid-transaction are ignored.
  - A completion still pulses to the granted port even if it dropped its request, which is illegal under Avalon.
  - A write with `byteenable=00` still runs a full cycle with both lanes disabled.
- The non-granted port holds `waitrequest=1`. `pN_readdata` holds its last captured value.

## Timing
- **Reset values**, applied immediately on `reset_reset_n` low, with no clock needed:
  - state is IDLE;
  - `tcm_chipselect_n_out`, `tcm_read_n_out`, `tcm_write_n_out` are 1;
  - `tcm_byteenable_n_out` is 2'b11;
  - `tcm_address_out` is 0;
  - `tcm_data` is high-Z;
  - `p0_waitrequest` and `p1_waitrequest` are 1;
  - `p0_readdata` and `p1_readdata` are 0;
  - `last_grant` is 1.
- **Reset during a transaction:** the access is aborted, with strobes high and the bus released in the same instant. No completion is issued.
- **Latency:** a request seen in IDLE at edge 0 sees `waitrequest` low in cycle `1+SETUP_CYCLES+ACCESS_CYCLES`.
- **Transaction length:** one transaction occupies `1+SETUP+ACCESS+HOLD` cycles. With defaults that is 5 cycles, and completion is in cycle 4.
- **Back-to-back traffic:** there is always at least one IDLE cycle between transactions with `cs_n` high, which provides bus turnaround.
- **Write strobe:** `write_n` never falls in the same cycle that `cs_n` or the address changes. Data is stable from SETUP until the end of HOLD.
- **Registered outputs:** all pin outputs are registered, with no combinational path from `pN_*` to `tcm_*`.

## Test plan
- **Single read, defaults**
  - Stimulus: p0 reads address `0x1ABCD`; the SRAM model returns `0xBEEF`.
  - Required: `cs_n` low for cycles 1-4; `read_n` low for cycles 2-3; `p0_waitrequest=0` only in cycle 4 with `p0_readdata=0xBEEF`.
- **Single write**
  - Stimulus: p1 writes `0x1234` to `0x00010` with `be=2'b01`.
  - Required: `byteenable_n=2'b10`; data driven in cycles 1-4; `write_n` low in cycles 2-3; high-Z in cycle 5.
- **Contention**
  - Stimulus: both ports request continuously from reset.
  - Required: grants go p0, p1, p0, p1; each completion is 5 cycles apart; the losing port's `waitrequest` stays 1.
- **Parameter sweep**
  - Stimulus: `SETUP=3`, `ACCESS=4`, `HOLD=2` for a read.
  - Required: completion in cycle 8; `read_n` low for exactly 4 cycles; 10 cycles from request to IDLE.
- **Mid-transaction reset**
  - Stimulus: assert reset during ACCESS of a write.
  - Required: `write_n` and `cs_n` go to 1 and the bus goes high-Z asynchronously; no waitrequest pulse; after release, p0 wins the first tie.
- **Request dropped**
  - Stimulus: p0 deasserts `read` during SETUP.
  - Required: the access completes unchanged and `p0_waitrequest` pulses once.
